apb2axi_apb_master: RTL
=======================

APB2AXI_APB_MASTER -- requirements
Module: apb2axi_apb_master

Interface
REQ-001 SHALL have parameter APB_ADDR_W, default APB_ADDR_W from apb2axi_pkg, APB address width.
REQ-002 SHALL have parameter APB_DATA_W, default APB_DATA_W from apb2axi_pkg, APB data width.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 256, max consecutive ACCESS cycles with pready low before abort; legal range 2..65535.
REQ-004 SHALL use one clock; reset is synchronous and active-low, sampled on the pclk rising edge.
REQ-005 pclk  in  1  clock.
REQ-006 presetn  in  1  synchronous active-low reset.
REQ-007 cmd_valid  in  1  command request.
REQ-008 cmd_ready  out  1  command accepted this cycle.
REQ-009 cmd_write  in  1  1=write, 0=read.
REQ-010 cmd_addr  in  APB_ADDR_W  target address.
REQ-011 cmd_wdata  in  APB_DATA_W  write data.
REQ-012 rsp_valid  out  1  response available.
REQ-013 rsp_ready  in  1  response consumed.
REQ-014 rsp_rdata  out  APB_DATA_W  read data; 0 for writes and timeouts.
REQ-015 rsp_err  out  1  pslverr sampled, or timeout.
REQ-016 rsp_timeout  out  1  transfer aborted by timeout.
REQ-017 psel, penable, pwrite  out  1 each  APB control.
REQ-018 paddr  out  APB_ADDR_W; pwdata  out  APB_DATA_W.
REQ-019 pready, pslverr  in  1 each; prdata  in  APB_DATA_W.

Function
REQ-020 SHALL implement FSM S_IDLE, S_SETUP, S_ACCESS, S_RESP, with all outputs registered except cmd_ready.
REQ-021 cmd_ready SHALL equal (state==S_IDLE), combinational from state only.
REQ-022 On cmd_valid&&cmd_ready, SHALL latch cmd_write/addr/wdata into pwrite/paddr/pwdata and go S_SETUP.
REQ-023 S_SETUP: psel=1, penable=0; next state S_ACCESS unconditionally.
REQ-024 S_ACCESS: psel=1, penable=1; paddr/pwrite/pwdata SHALL stay stable from SETUP to transfer end.
REQ-025 In S_ACCESS with pready=1: capture prdata (reads only, else 0) into rsp_rdata, pslverr into rsp_err, rsp_timeout=0; drop psel/penable; go S_RESP.
REQ-026 In S_ACCESS with pready=0: increment 16-bit wait counter; counter SHALL clear on entry to S_SETUP.
REQ-027 When the wait counter reaches TIMEOUT_CYC-1 with pready still low: drop psel/penable; rsp_err=1, rsp_timeout=1, rsp_rdata=0; go S_RESP.
REQ-028 Same-cycle pready=1 and timeout threshold: pready SHALL win (normal completion).
REQ-029 S_RESP: rsp_valid=1, response fields held stable until rsp_ready=1; then next state S_IDLE.
REQ-030 Latency: accept at edge N -> psel at N+1, penable at N+2, rsp_valid at N+3 for zero wait states; minimum command-to-command spacing 4 cycles.
REQ-031 Never SHALL psel drop without a completed or aborted ACCESS; penable SHALL never be 1 while psel=0.
REQ-032 cmd_* values while cmd_ready=0 SHALL be ignored.

Reset
REQ-033 With presetn=0: state=S_IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, wait counter=0.
REQ-034 Reset asserted mid-transfer SHALL deassert psel/penable at the next edge and discard any pending response.

Verification
REQ-035 Write addr=0x08 data=0x8000_0103, pready=1 -> psel at N+1, penable at N+2, rsp_valid at N+3, rsp_err=0, rsp_rdata=0.
REQ-036 Read addr=0x0C, pready low 3 ACCESS cycles then high with prdata=0x0000_8123 -> penable held 4 cycles, paddr stable, rsp_rdata=0x0000_8123.
REQ-037 Read with pslverr=1 on pready -> rsp_err=1, rsp_timeout=0.
REQ-038 TIMEOUT_CYC=4, pready held 0 -> psel/penable drop after 4 ACCESS cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-039 rsp_ready held 0 for 5 cycles with cmd_valid=1 -> cmd_ready stays 0, response fields unchanged, new command accepted only after rsp_ready.
REQ-040 presetn=0 during S_ACCESS -> psel=penable=0 next cycle, rsp_valid=0, cmd_ready=1 after reset release.

Source files
------------

// File: rtl/apb2axi_pkg.sv
// Shared widths for the APB side of the APB-to-AXI bridge.
// No logic; parameters only.
// Consumers override these per instance if a narrower bus is needed.
package apb2axi_pkg;

  parameter int APB_ADDR_W = 32;
  parameter int APB_DATA_W = 32;

endpackage : apb2axi_pkg

// File: rtl/apb2axi_apb_master.sv
// Single-outstanding APB requester: one command in, one APB transfer, one response out.
// Latency: accept in cycle N -> psel N+1, penable N+2, rsp_valid N+3 with zero wait states.
// Backpressure: cmd_ready only in idle; response held until rsp_ready; slow slaves aborted after TIMEOUT_CYC.
module apb2axi_apb_master #(
  parameter int APB_ADDR_W  = apb2axi_pkg::APB_ADDR_W,
  parameter int APB_DATA_W  = apb2axi_pkg::APB_DATA_W,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                  pclk,
  input  logic                  presetn,
  // command side
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [APB_ADDR_W-1:0] cmd_addr,
  input  logic [APB_DATA_W-1:0] cmd_wdata,
  // response side
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [APB_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  // APB requester port
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [APB_ADDR_W-1:0] paddr,
  output logic [APB_DATA_W-1:0] pwdata,
  input  logic                  pready,
  input  logic                  pslverr,
  input  logic [APB_DATA_W-1:0] prdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  // Counter value on the last ACCESS cycle before the transfer is abandoned.
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state;
  logic [15:0] wait_cnt;

  // Commands are only taken while nothing is in flight; depends on state alone.
  assign cmd_ready = (state == S_IDLE);

  // Transfer sequencer: every APB and response output is a register written here.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state       <= S_IDLE;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            // Address/control/data are frozen here and stay put for the whole transfer.
            pwrite   <= cmd_write;
            paddr    <= cmd_addr;
            pwdata   <= cmd_wdata;
            psel     <= 1'b1;
            penable  <= 1'b0;
            wait_cnt <= '0;
            state    <= S_SETUP;
          end
        end

        S_SETUP: begin
          penable <= 1'b1;
          state   <= S_ACCESS;
        end

        S_ACCESS: begin
          // pready is tested first so a completion on the threshold cycle is not lost.
          if (pready) begin
            rsp_rdata   <= pwrite ? '0 : prdata;
            rsp_err     <= pslverr;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            psel        <= 1'b0;
            penable     <= 1'b0;
            state       <= S_RESP;
          end else if (wait_cnt == WAIT_LAST) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            psel        <= 1'b0;
            penable     <= 1'b0;
            state       <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule : apb2axi_apb_master
